spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
Command sequencer that sits directly upstream of the SPI byte engine (`spicore`), driving its byte interface (`we`/`spi_di`/`spi_do`/`ready`/`spi_ss_reset`).
On a `start` request it issues a flash read command, a 24-bit address and optional dummy bytes, then clocks out `len` data bytes.
Each received byte is delivered on a valid/ready byte stream to the consumer (boot loader / CPU bus bridge).
At the end it releases chip select through `spi_ss_reset`.

Parameters:
- CMD, 8'h03, flash read opcode sent as byte 0.
- DUMMY_BYTES, 0, number of 8'h00 bytes sent after the address; received data is discarded (set 1 with CMD=8'h0B).
- LEN_W, 16, width of the byte-count input.

Ports:
- clk  input  1  system clock; shared with the byte engine.
- reset  input  1  synchronous, active-low reset. Low = held in reset, sampled on the clk rising edge.
- start  input  1  one-cycle request; sampled only in IDLE.
- addr  input  24  flash byte address; captured on start.
- len  input  LEN_W  number of data bytes to read; captured on start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of transaction.
- rd_data  output  8  received data byte.
- rd_valid  output  1  rd_data holds an unconsumed byte.
- rd_ready  input  1  consumer accepts; a transfer occurs when rd_valid&rd_ready.
- core_we  output  1  byte-engine write strobe.
- core_di  output  8  byte to transmit.
- core_do  input  8  last received byte.
- core_ready  input  1  byte engine idle / last byte complete.
- core_ss_reset  output  1  deasserts flash chip select.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=BOOT; busy=0, done=0, rd_valid=0, rd_data=0, core_we=0, core_di=0, core_ss_reset=0.
  - Captured addr/len and all counters are cleared.
- States: BOOT, IDLE, SEND, WAIT, FINISH.
- BOOT: wait for core_ready==1 (the byte engine's flash-reset sequence has finished), then go to IDLE. start is ignored in BOOT.
- IDLE:
  - start==1 and len!=0: latch addr/len, busy=1, phase=CMD, go to SEND.
  - start==1 and len==0: pulse done for one cycle next cycle, busy stays 0, no SPI activity.
- SEND:
  - Drive core_we=1 for exactly one cycle; core_di is the phase byte:
    - CMD phase: CMD.
    - ADDR phase: addr[23:16], then [15:8], then [7:0].
    - DUMMY and DATA phases: 8'h00.
  - Next state is WAIT.
  - A DATA-phase SEND is entered only if rd_valid==0, or rd_valid&rd_ready in that same cycle. Otherwise stall in WAIT, keeping the request pending.
- WAIT:
  - The first cycle after SEND always sees core_ready==0.
  - On core_ready==1: in DATA phase, load rd_data<=core_do and rd_valid<=1 on the next edge.
  - Then advance the phase/byte counter and go to SEND, or to FINISH after the last data byte.
- Byte period without backpressure: 10 clk per byte, i.e. core_we cycle to core_we cycle.
- The first data byte is presented 10×(4+DUMMY_BYTES+1) cycles after the first core_we.
- FINISH:
  - Assert core_ss_reset for one cycle; core_ready is 1 here.
  - The next cycle: done=1, busy=0, state=IDLE.
  - The final rd_valid byte may still be pending in IDLE; a new start is accepted only once rd_valid==0.
- rd_valid clears on rd_valid&rd_ready unless it is reloaded in the same cycle; a reload has priority.
- core_we is never asserted when core_ready==0. core_ss_reset is never asserted outside FINISH.
- start while busy is ignored; captured addr/len do not change.
- Reset mid-transaction: all outputs return to reset values at the next edge and the FSM returns to BOOT. Any partially read data is dropped.
- Counters:
  - Byte counter is LEN_W bits and counts down from len to 0.
  - Header counter is 3 bits and covers CMD + 3 address bytes + DUMMY_BYTES.
  - DUMMY_BYTES is limited to 0..3.

Decomposition:
- Shared package (`spi_flash_pkg`):
  - State encoding enum (BOOT/IDLE/SEND/WAIT/FINISH).
  - Phase enum (CMD/ADDR/DUMMY/DATA).
  - Opcode constants: `FLASH_CMD_READ` = 8'h03, `FLASH_CMD_FAST_READ` = 8'h0B.
- One natural sub-module, `byte_hold_reg`: a single-entry valid/ready holding register containing rd_data/rd_valid and the load/drain priority logic.

Test Plan:
- Release reset with a byte-engine model that holds core_ready=0 for 40 cycles: no core_we until core_ready=1; busy=0 throughout.
- start, addr=24'h012345, len=4, MISO model returns A1 B2 C3 D4 in the data phase, rd_ready=1:
  - MOSI bytes are 03 01 23 45 00 00 00 00.
  - rd stream delivers A1 B2 C3 D4.
  - core_ss_reset pulses once, then done pulses once.
- Same transfer with rd_ready held 0 for 50 cycles after the first byte: no core_we during the stall; no byte lost or duplicated; order preserved.
- start with len=0: done pulses one cycle after start; core_we never asserted; busy stays 0.
- Second start asserted mid-transfer: ignored; MOSI address bytes unchanged.
- reset low during the 3rd data byte: outputs at reset values next edge; FSM returns to BOOT.
- Build with CMD=8'h0B, DUMMY_BYTES=1, len=2: MOSI is 0B aa bb cc 00 00 00; only the last two received bytes appear on rd_data.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_CMD,
    PH_ADDR,
    PH_DUMMY,
    PH_DATA
  } phase_t;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

  // Maps a header byte index to its phase: 0 is the opcode, 1..3 the
  // address bytes, then the dummy bytes, and everything after is data.
  function automatic phase_t hdrPhase(input logic [2:0] idx, input int dummyBytes);
    phase_t ph;
    if (idx == 3'd0)                    ph = PH_CMD;
    else if (int'(idx) <= 3)            ph = PH_ADDR;
    else if (int'(idx) <= 3 + dummyBytes) ph = PH_DUMMY;
    else                                ph = PH_DATA;
    return ph;
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Bundle of the request, read-stream and byte-engine signals of the reader.
// slave is the reader's view, master is the view of its surroundings.
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             core_we;
  logic [7:0]       core_di;
  logic [7:0]       core_do;
  logic             core_ready;
  logic             core_ss_reset;

  modport slave (
    input  start, addr, len, rd_ready, core_do, core_ready,
    output busy, done, rd_data, rd_valid, core_we, core_di, core_ss_reset
  );

  modport master (
    output start, addr, len, rd_ready, core_do, core_ready,
    input  busy, done, rd_data, rd_valid, core_we, core_di, core_ss_reset
  );
endinterface

// File: rtl/spi_flash_reader_byte_hold.sv
// Single-entry valid/ready holding register for received data bytes.
module byte_hold_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid
);

  logic [7:0] r_data;
  logic       r_valid;

  // A load wins over a drain in the same cycle so a back-to-back byte is kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/spi_flash_reader.sv
// Flash read command sequencer driving the SPI byte engine: sends opcode,
// 24-bit address and dummy bytes, then clocks in len data bytes onto a
// valid/ready stream and finally releases chip select.
// DUMMY_BYTES must stay within 0..3 so the header index fits in 3 bits.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] CMD         = FLASH_CMD_READ,
  parameter int         DUMMY_BYTES = 0,
  parameter int         LEN_W       = 16
) (
  input logic              clk,
  input logic              reset,
  spi_flash_reader_if.slave bus
);

  state_t           r_state;
  phase_t           r_phase;
  logic [2:0]       r_hdrIdx;
  logic [LEN_W-1:0] r_byteCnt;
  logic [23:0]      r_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_coreWe;
  logic [7:0]       r_coreDi;
  logic             r_ssReset;

  logic [2:0]       w_nextIdx;
  phase_t           w_nextPhase;
  logic [7:0]       w_hdrByte;
  logic             w_rdValid;
  logic [7:0]       w_rdData;
  logic             w_holdFree;
  logic             w_needHold;
  logic             w_advance;
  logic             w_load;

  assign w_nextIdx   = r_hdrIdx + 3'd1;
  assign w_nextPhase = hdrPhase(w_nextIdx, DUMMY_BYTES);

  // The holding register must be free (or draining) before a data byte is
  // either captured or requested; otherwise the engine is left idle.
  assign w_holdFree = !w_rdValid || bus.rd_ready;
  assign w_needHold = (r_phase == PH_DATA) || (w_nextPhase == PH_DATA);
  assign w_advance  = (r_state == ST_WAIT) && bus.core_ready && (!w_needHold || w_holdFree);
  assign w_load     = w_advance && (r_phase == PH_DATA);

  // Header byte to transmit for the next header index.
  always_comb begin
    w_hdrByte = 8'h00;
    case (w_nextIdx)
      3'd1:    w_hdrByte = r_addr[23:16];
      3'd2:    w_hdrByte = r_addr[15:8];
      3'd3:    w_hdrByte = r_addr[7:0];
      default: w_hdrByte = 8'h00;
    endcase
  end

  // Main sequencer: every output is registered and strobes default low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_BOOT;
      r_phase   <= PH_CMD;
      r_hdrIdx  <= 3'd0;
      r_byteCnt <= '0;
      r_addr    <= 24'h0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_coreWe  <= 1'b0;
      r_coreDi  <= 8'h00;
      r_ssReset <= 1'b0;
    end else begin
      r_coreWe  <= 1'b0;
      r_done    <= 1'b0;
      r_ssReset <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          if (bus.core_ready) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.start && !w_rdValid) begin
            if (bus.len != '0) begin
              r_addr    <= bus.addr;
              r_byteCnt <= bus.len;
              r_hdrIdx  <= 3'd0;
              r_phase   <= PH_CMD;
              r_busy    <= 1'b1;
              r_coreWe  <= 1'b1;
              r_coreDi  <= CMD;
              r_state   <= ST_SEND;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_advance) begin
            if (r_phase == PH_DATA) begin
              r_byteCnt <= r_byteCnt - LEN_W'(1);
              if (r_byteCnt == LEN_W'(1)) begin
                r_ssReset <= 1'b1;
                r_state   <= ST_FINISH;
              end else begin
                r_coreWe <= 1'b1;
                r_coreDi <= 8'h00;
                r_state  <= ST_SEND;
              end
            end else begin
              r_hdrIdx <= w_nextIdx;
              r_phase  <= w_nextPhase;
              r_coreWe <= 1'b1;
              r_coreDi <= w_hdrByte;
              r_state  <= ST_SEND;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  byte_hold_reg u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (bus.core_do),
    .i_ready (bus.rd_ready),
    .o_data  (w_rdData),
    .o_valid (w_rdValid)
  );

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.rd_data       = w_rdData;
  assign bus.rd_valid      = w_rdValid;
  assign bus.core_we       = r_coreWe;
  assign bus.core_di       = r_coreDi;
  assign bus.core_ss_reset = r_ssReset;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: instance A is a plain READ (0x03),
// instance B a FAST READ (0x0B) with one dummy byte. Each is driven by a
// small byte-engine model that takes 10 clocks per byte and a 40-cycle boot.
module tb_spi_flash_reader;
  import spi_flash_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_flash_reader_if #(.LEN_W(16)) ifA ();
  spi_flash_reader_if #(.LEN_W(16)) ifB ();

  spi_flash_reader #(.CMD(FLASH_CMD_READ), .DUMMY_BYTES(0), .LEN_W(16)) dutA (
    .clk(clk), .reset(reset), .bus(ifA.slave));
  spi_flash_reader #(.CMD(FLASH_CMD_FAST_READ), .DUMMY_BYTES(1), .LEN_W(16)) dutB (
    .clk(clk), .reset(reset), .bus(ifB.slave));

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [7:0] respA [16];
  logic [7:0] respB [16];

  logic [7:0] mosiA [$];
  logic [7:0] rxA [$];
  int         weCycA [$];
  int         validRiseA [$];
  logic [7:0] mosiB [$];
  logic [7:0] rxB [$];
  int         weCycB [$];
  int         validRiseB [$];
  int ssA = 0, doneA = 0, weBusyA = 0, ssB = 0, doneB = 0, weBusyB = 0;
  logic prevValidA = 1'b0, prevValidB = 1'b0;

  int bootA, cntA, idxA, bootB, cntB, idxB;

  // Free-running cycle counter used to time-stamp monitor events.
  always @(posedge clk) cycle <= cycle + 1;

  // Byte-engine model A: 40-cycle boot, then 8 busy cycles per byte.
  always @(posedge clk) begin
    if (!reset) begin
      ifA.core_ready <= 1'b0; ifA.core_do <= 8'h00; bootA <= 40; cntA <= 0; idxA <= 0;
    end else if (bootA != 0) begin
      bootA <= bootA - 1;
      if (bootA == 1) ifA.core_ready <= 1'b1;
    end else if (ifA.core_we) begin
      ifA.core_ready <= 1'b0; cntA <= 7;
    end else if (ifA.core_ss_reset) begin
      idxA <= 0;
    end else if (!ifA.core_ready) begin
      if (cntA == 0) begin
        ifA.core_ready <= 1'b1; ifA.core_do <= respA[idxA[3:0]]; idxA <= idxA + 1;
      end else cntA <= cntA - 1;
    end
  end

  // Byte-engine model B, identical timing.
  always @(posedge clk) begin
    if (!reset) begin
      ifB.core_ready <= 1'b0; ifB.core_do <= 8'h00; bootB <= 40; cntB <= 0; idxB <= 0;
    end else if (bootB != 0) begin
      bootB <= bootB - 1;
      if (bootB == 1) ifB.core_ready <= 1'b1;
    end else if (ifB.core_we) begin
      ifB.core_ready <= 1'b0; cntB <= 7;
    end else if (ifB.core_ss_reset) begin
      idxB <= 0;
    end else if (!ifB.core_ready) begin
      if (cntB == 0) begin
        ifB.core_ready <= 1'b1; ifB.core_do <= respB[idxB[3:0]]; idxB <= idxB + 1;
      end else cntB <= cntB - 1;
    end
  end

  // Monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (ifA.core_we) begin
        mosiA.push_back(ifA.core_di); weCycA.push_back(cycle);
        if (!ifA.core_ready) weBusyA <= weBusyA + 1;
      end
      if (ifA.rd_valid && ifA.rd_ready) rxA.push_back(ifA.rd_data);
      if (ifA.rd_valid && !prevValidA) validRiseA.push_back(cycle);
      if (ifA.core_ss_reset) ssA <= ssA + 1;
      if (ifA.done) doneA <= doneA + 1;
      if (ifB.core_we) begin
        mosiB.push_back(ifB.core_di); weCycB.push_back(cycle);
        if (!ifB.core_ready) weBusyB <= weBusyB + 1;
      end
      if (ifB.rd_valid && ifB.rd_ready) rxB.push_back(ifB.rd_data);
      if (ifB.rd_valid && !prevValidB) validRiseB.push_back(cycle);
      if (ifB.core_ss_reset) ssB <= ssB + 1;
      if (ifB.done) doneB <= doneB + 1;
    end
    prevValidA <= ifA.rd_valid;
    prevValidB <= ifB.rd_valid;
  end

  // Pulses start on A for one cycle with the given address and length.
  task automatic pulseStartA(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #2;
    ifA.start = 1'b1; ifA.addr = a; ifA.len = n;
    @(posedge clk); #2;
    ifA.start = 1'b0;
  endtask

  task automatic test_reset();
    int weSeen = 0, busySeen = 0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ifA.busy, ifA.done, ifA.rd_valid, ifA.core_we, ifA.core_ss_reset, ifA.rd_data, ifA.core_di} !== 21'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_A: got %06h, want 000000",
               {ifA.busy, ifA.done, ifA.rd_valid, ifA.core_we, ifA.core_ss_reset, ifA.rd_data, ifA.core_di});
    end
    vectors++;
    if ({ifB.busy, ifB.done, ifB.rd_valid, ifB.core_we, ifB.core_ss_reset, ifB.rd_data, ifB.core_di} !== 21'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_B: got %06h, want 000000",
               {ifB.busy, ifB.done, ifB.rd_valid, ifB.core_we, ifB.core_ss_reset, ifB.rd_data, ifB.core_di});
    end
    @(posedge clk); #2 reset = 1'b1;
    pulseStartA(24'h012345, 16'd4);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (ifA.core_we) weSeen++;
      if (ifA.busy) busySeen++;
    end
    vectors++;
    if (weSeen != 0) begin
      miscompares++; $display("[TB] FAIL boot_no_we: got %0d core_we cycles, want 0", weSeen);
    end
    vectors++;
    if (busySeen != 0) begin
      miscompares++; $display("[TB] FAIL boot_busy: got %0d busy cycles, want 0", busySeen);
    end
    for (int i = 0; i < 40 && !(ifA.core_ready && ifB.core_ready); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (mosiA.size() != 0 || ifA.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL boot_start_ignored: got %0d bytes busy=%b, want 0 bytes busy=0", mosiA.size(), ifA.busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] expMosi [8] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] expRx [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int s0 = ssA, d0 = doneA;
    mosiA.delete(); rxA.delete(); weCycA.delete(); validRiseA.delete();
    ifA.rd_ready = 1'b1;
    pulseStartA(24'h012345, 16'd4);
    @(negedge clk);
    vectors++;
    if (ifA.busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL basic_busy: got %b, want 1", ifA.busy);
    end
    for (int i = 0; i < 200 && doneA == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (doneA != d0 + 1) begin
      miscompares++; $display("[TB] FAIL basic_done_count: got %0d, want 1", doneA - d0);
    end
    vectors++;
    if (ssA != s0 + 1) begin
      miscompares++; $display("[TB] FAIL basic_ss_count: got %0d, want 1", ssA - s0);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= mosiA.size() || mosiA[i] !== expMosi[i]) begin
        miscompares++; $display("[TB] FAIL basic_mosi[%0d]: got %02h (n=%0d), want %02h", i, (i < mosiA.size()) ? mosiA[i] : 8'h00, mosiA.size(), expMosi[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= rxA.size() || rxA[i] !== expRx[i]) begin
        miscompares++; $display("[TB] FAIL basic_rx[%0d]: got %02h (n=%0d), want %02h", i, (i < rxA.size()) ? rxA[i] : 8'h00, rxA.size(), expRx[i]);
      end
    end
    vectors++;
    if (rxA.size() != 4) begin
      miscompares++; $display("[TB] FAIL basic_rx_count: got %0d, want 4", rxA.size());
    end
    vectors++;
    if (weCycA.size() < 8 || weCycA[1] - weCycA[0] != 10 || weCycA[6] - weCycA[5] != 10) begin
      miscompares++; $display("[TB] FAIL basic_byte_period: got %0d entries, want period 10", weCycA.size());
    end
    vectors++;
    if (weCycA.size() == 0 || validRiseA.size() == 0 || validRiseA[0] - weCycA[0] != 50) begin
      miscompares++; $display("[TB] FAIL basic_first_data_latency: got %0d, want 50",
                              (weCycA.size() > 0 && validRiseA.size() > 0) ? validRiseA[0] - weCycA[0] : -1);
    end
    vectors++;
    if (weBusyA != 0 || ifA.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_we_vs_ready: got %0d bad strobes busy=%b, want 0 busy=0", weBusyA, ifA.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] expRx [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int d0 = doneA, stallWe = 0;
    mosiA.delete(); rxA.delete();
    ifA.rd_ready = 1'b0;
    pulseStartA(24'h012345, 16'd4);
    for (int i = 0; i < 200 && !ifA.rd_valid; i++) @(negedge clk);
    vectors++;
    if (ifA.rd_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_first_valid: got %b, want 1", ifA.rd_valid);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifA.core_we) stallWe++;
    end
    vectors++;
    if (stallWe != 0) begin
      miscompares++; $display("[TB] FAIL bp_stall_we: got %0d strobes, want 0", stallWe);
    end
    vectors++;
    if (ifA.rd_valid !== 1'b1 || ifA.rd_data !== 8'hA1) begin
      miscompares++; $display("[TB] FAIL bp_hold_data: got %b/%02h, want 1/a1", ifA.rd_valid, ifA.rd_data);
    end
    @(posedge clk); #2 ifA.rd_ready = 1'b1;
    for (int i = 0; i < 200 && doneA == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (rxA.size() != 4 || mosiA.size() != 8 || doneA != d0 + 1) begin
      miscompares++; $display("[TB] FAIL bp_counts: got rx=%0d mosi=%0d done=%0d, want 4/8/1", rxA.size(), mosiA.size(), doneA - d0);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= rxA.size() || rxA[i] !== expRx[i]) begin
        miscompares++; $display("[TB] FAIL bp_rx[%0d]: got %02h, want %02h", i, (i < rxA.size()) ? rxA[i] : 8'h00, expRx[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    int w0 = mosiA.size();
    pulseStartA(24'h00ABCD, 16'd0);
    @(negedge clk);
    vectors++;
    if (ifA.done !== 1'b1 || ifA.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL len0_done: got done=%b busy=%b, want 1/0", ifA.done, ifA.busy);
    end
    @(negedge clk);
    vectors++;
    if (ifA.done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL len0_done_width: got %b, want 0", ifA.done);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (mosiA.size() != w0 || ifA.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL len0_no_spi: got %0d bytes busy=%b, want 0 bytes busy=0", mosiA.size() - w0, ifA.busy);
    end
  endtask

  task automatic test_back_to_back_start();
    logic [7:0] expMosi [6] = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00};
    int d0 = doneA;
    mosiA.delete(); rxA.delete();
    pulseStartA(24'hABCDEF, 16'd2);
    repeat (25) @(negedge clk);
    pulseStartA(24'h777777, 16'd9);
    for (int i = 0; i < 200 && doneA == d0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    vectors++;
    if (mosiA.size() != 6 || rxA.size() != 2 || doneA != d0 + 1) begin
      miscompares++; $display("[TB] FAIL busy_start_counts: got mosi=%0d rx=%0d done=%0d, want 6/2/1", mosiA.size(), rxA.size(), doneA - d0);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= mosiA.size() || mosiA[i] !== expMosi[i]) begin
        miscompares++; $display("[TB] FAIL busy_start_mosi[%0d]: got %02h, want %02h", i, (i < mosiA.size()) ? mosiA[i] : 8'h00, expMosi[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] expMosi [5] = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
    int weSeen = 0, d0;
    mosiA.delete(); rxA.delete();
    ifA.rd_ready = 1'b1;
    pulseStartA(24'h012345, 16'd4);
    for (int i = 0; i < 300 && rxA.size() < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ifA.busy, ifA.done, ifA.rd_valid, ifA.core_we, ifA.core_ss_reset, ifA.rd_data, ifA.core_di} !== 21'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %06h, want 000000",
               {ifA.busy, ifA.done, ifA.rd_valid, ifA.core_we, ifA.core_ss_reset, ifA.rd_data, ifA.core_di});
    end
    @(posedge clk); #2 reset = 1'b1;
    pulseStartA(24'h012345, 16'd4);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifA.core_we || ifA.busy) weSeen++;
    end
    vectors++;
    if (weSeen != 0 || rxA.size() != 2) begin
      miscompares++; $display("[TB] FAIL midreset_back_to_boot: got %0d active cycles rx=%0d, want 0/2", weSeen, rxA.size());
    end
    for (int i = 0; i < 40 && !(ifA.core_ready && ifB.core_ready); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    mosiA.delete(); rxA.delete();
    d0 = doneA;
    pulseStartA(24'h000010, 16'd1);
    for (int i = 0; i < 200 && doneA == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (rxA.size() != 1 || (rxA.size() == 1 && rxA[0] !== 8'hA1) || mosiA.size() != 5) begin
      miscompares++; $display("[TB] FAIL midreset_recover: got rx=%0d mosi=%0d, want 1 byte a1 / 5", rxA.size(), mosiA.size());
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= mosiA.size() || mosiA[i] !== expMosi[i]) begin
        miscompares++; $display("[TB] FAIL midreset_mosi[%0d]: got %02h, want %02h", i, (i < mosiA.size()) ? mosiA[i] : 8'h00, expMosi[i]);
      end
    end
  endtask

  task automatic test_fast_read_dummy();
    logic [7:0] expMosi [7] = '{8'h0B, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00};
    int d0 = doneB, s0 = ssB;
    mosiB.delete(); rxB.delete(); weCycB.delete(); validRiseB.delete();
    ifB.rd_ready = 1'b1;
    @(posedge clk); #2;
    ifB.start = 1'b1; ifB.addr = 24'hAABBCC; ifB.len = 16'd2;
    @(posedge clk); #2;
    ifB.start = 1'b0;
    for (int i = 0; i < 300 && doneB == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (doneB != d0 + 1 || ssB != s0 + 1 || weBusyB != 0) begin
      miscompares++; $display("[TB] FAIL fast_done_ss: got done=%0d ss=%0d bad=%0d, want 1/1/0", doneB - d0, ssB - s0, weBusyB);
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (i >= mosiB.size() || mosiB[i] !== expMosi[i]) begin
        miscompares++; $display("[TB] FAIL fast_mosi[%0d]: got %02h (n=%0d), want %02h", i, (i < mosiB.size()) ? mosiB[i] : 8'h00, mosiB.size(), expMosi[i]);
      end
    end
    vectors++;
    if (rxB.size() != 2 || (rxB.size() == 2 && (rxB[0] !== 8'h11 || rxB[1] !== 8'h22))) begin
      miscompares++; $display("[TB] FAIL fast_rx: got n=%0d first=%02h, want 2 bytes 11 22", rxB.size(), (rxB.size() > 0) ? rxB[0] : 8'h00);
    end
    vectors++;
    if (weCycB.size() == 0 || validRiseB.size() == 0 || validRiseB[0] - weCycB[0] != 60) begin
      miscompares++; $display("[TB] FAIL fast_first_data_latency: got %0d, want 60",
                              (weCycB.size() > 0 && validRiseB.size() > 0) ? validRiseB[0] - weCycB[0] : -1);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    ifA.start = 1'b0; ifA.addr = 24'h0; ifA.len = 16'd0; ifA.rd_ready = 1'b1;
    ifB.start = 1'b0; ifB.addr = 24'h0; ifB.len = 16'd0; ifB.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      respA[i] = 8'hEE;
      respB[i] = 8'hEE;
    end
    respA[4] = 8'hA1; respA[5] = 8'hB2; respA[6] = 8'hC3; respA[7] = 8'hD4;
    respB[4] = 8'h5A; respB[5] = 8'h11; respB[6] = 8'h22;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_back_to_back_start();
    test_reset_mid();
    test_fast_read_dummy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
